// File: rtl/sram_pkg.sv
// Shared defaults and power-state encoding for the banked SRAM array.
package sram_pkg;

    localparam int DEF_DATA_W     = 64;
    localparam int DEF_ADDR_W     = 12;
    localparam int DEF_BANK_AW    = 10;
    localparam int DEF_IDLE_SLEEP = 16;
    localparam int DEF_WAKE_CYC   = 2;

    typedef enum logic [1:0] {
        PWR_AWAKE,
        PWR_SLEEP,
        PWR_WAKE
    } pwr_state_t;

endpackage

// File: rtl/sram_bank.sv
// Single-port SRAM bank: bit-masked write, registered 1-cycle read, light-sleep gate.
module sram_bank
    import sram_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int AW     = DEF_BANK_AW
) (
    input  logic              i_clk,
    input  logic              i_en,
    input  logic              i_we,
    input  logic [AW-1:0]     i_addr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [DATA_W-1:0] i_bmask,
    input  logic              i_ls,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] mem [2**AW];

    // Read data is held between reads so the response stage can sample it late.
    always_ff @(posedge i_clk) begin
        if (i_en && !i_ls) begin
            if (i_we) begin
                mem[i_addr] <= (mem[i_addr] & ~i_bmask) | (i_wdata & i_bmask);
            end else begin
                o_rdata <= mem[i_addr];
            end
        end
    end

endmodule

// File: rtl/sram_bank_array.sv
// Banked SRAM array: request decode, two-stage read response pipeline and
// an idle-driven light-sleep power controller.
module sram_bank_array
    import sram_pkg::*;
#(
    parameter int DATA_W     = DEF_DATA_W,
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int BANK_AW    = DEF_BANK_AW,
    parameter int IDLE_SLEEP = DEF_IDLE_SLEEP,
    parameter int WAKE_CYC   = DEF_WAKE_CYC
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_req_valid,
    output logic              o_req_ready,
    input  logic              i_req_wen,
    input  logic [ADDR_W-1:0] i_req_addr,
    input  logic [DATA_W-1:0] i_req_wdata,
    input  logic [DATA_W-1:0] i_req_bmask,
    input  logic              i_sleep_en,
    output logic              o_rsp_valid,
    output logic [DATA_W-1:0] o_rsp_rdata,
    output logic              o_sleep
);

    localparam int N_BANKS = 2**(ADDR_W-BANK_AW);
    localparam int SEL_W   = ADDR_W - BANK_AW;
    localparam int IC_W    = $clog2(IDLE_SLEEP + 1);
    localparam int WC_W    = $clog2(WAKE_CYC + 1);
    localparam logic [IC_W-1:0] IDLE_MAX  = IC_W'(IDLE_SLEEP);
    localparam logic [WC_W-1:0] WAKE_LAST = WC_W'(WAKE_CYC - 1);

    pwr_state_t        state, state_nxt;
    logic [IC_W-1:0]   idle_cnt, idle_nxt;
    logic [WC_W-1:0]   wake_cnt, wake_nxt;
    logic              accept;
    logic              rd_accept;
    logic [SEL_W-1:0]  req_bank;
    logic [SEL_W-1:0]  rd_bank;
    logic              rd_pend;
    logic [DATA_W-1:0] bank_rdata [N_BANKS];

    assign o_req_ready = (state == PWR_AWAKE);
    assign o_sleep     = (state == PWR_SLEEP);
    assign accept      = i_req_valid && o_req_ready && !i_rst;
    assign rd_accept   = accept && !i_req_wen;
    assign req_bank    = i_req_addr[ADDR_W-1:BANK_AW];

    for (genvar b = 0; b < N_BANKS; b++) begin : g_bank
        sram_bank #(
            .DATA_W (DATA_W),
            .AW     (BANK_AW)
        ) u_bank (
            .i_clk   (i_clk),
            .i_en    (accept && (req_bank == SEL_W'(b))),
            .i_we    (i_req_wen),
            .i_addr  (i_req_addr[BANK_AW-1:0]),
            .i_wdata (i_req_wdata),
            .i_bmask (i_req_bmask),
            .i_ls    (o_sleep),
            .o_rdata (bank_rdata[b])
        );
    end

    // Bank index travels with the read so later requests cannot steer the mux.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            rd_pend     <= 1'b0;
            rd_bank     <= '0;
            o_rsp_valid <= 1'b0;
            o_rsp_rdata <= '0;
        end else begin
            rd_pend     <= rd_accept;
            if (rd_accept) begin
                rd_bank <= req_bank;
            end
            o_rsp_valid <= rd_pend;
            if (rd_pend) begin
                o_rsp_rdata <= bank_rdata[rd_bank];
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state    <= PWR_AWAKE;
            idle_cnt <= '0;
            wake_cnt <= '0;
        end else begin
            state    <= state_nxt;
            idle_cnt <= idle_nxt;
            wake_cnt <= wake_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        idle_nxt  = idle_cnt;
        wake_nxt  = wake_cnt;
        case (state)
            PWR_AWAKE: begin
                if (accept || rd_pend) begin
                    idle_nxt = '0;
                end else if (idle_cnt != IDLE_MAX) begin
                    idle_nxt = idle_cnt + 1'b1;
                end
                if ((idle_cnt == IDLE_MAX) && i_sleep_en) begin
                    state_nxt = PWR_SLEEP;
                    idle_nxt  = '0;
                end
            end
            PWR_SLEEP: begin
                if (i_req_valid) begin
                    state_nxt = PWR_WAKE;
                    wake_nxt  = '0;
                end
            end
            PWR_WAKE: begin
                if (wake_cnt == WAKE_LAST) begin
                    state_nxt = PWR_AWAKE;
                end else begin
                    wake_nxt = wake_cnt + 1'b1;
                end
            end
            default: state_nxt = PWR_AWAKE;
        endcase
    end

endmodule

// File: tb/tb_sram_bank_array.sv
// Scoreboard bench for sram_bank_array: random and directed traffic checked
// against a word-level memory model with per-bit "known" tracking.
module tb_sram_bank_array;

    localparam int DW = 64;
    localparam int AW = 12;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid;
    logic          req_ready;
    logic          req_wen;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] bmask;
    logic          sleep_en;
    logic          rsp_valid;
    logic [DW-1:0] rdata;
    logic          sleep_o;

    always #5 clk = ~clk;

    sram_bank_array #(
        .DATA_W     (DW),
        .ADDR_W     (AW),
        .BANK_AW    (10),
        .IDLE_SLEEP (16),
        .WAKE_CYC   (2)
    ) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_req_valid (req_valid),
        .o_req_ready (req_ready),
        .i_req_wen   (req_wen),
        .i_req_addr  (req_addr),
        .i_req_wdata (wdata),
        .i_req_bmask (bmask),
        .i_sleep_en  (sleep_en),
        .o_rsp_valid (rsp_valid),
        .o_rsp_rdata (rdata),
        .o_sleep     (sleep_o)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always @(posedge clk) cyc = cyc + 1;

    logic [DW-1:0] ref_mem   [int];
    logic [DW-1:0] ref_known [int];

    typedef struct {
        logic [DW-1:0] data;
        logic [DW-1:0] known;
        int            acc;
    } exp_t;

    exp_t sbq[$];
    exp_t mon_e;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    task automatic model_accept(input logic wen, input int addr, input logic [DW-1:0] d,
                                input logic [DW-1:0] m);
        exp_t e;
        if (!ref_mem.exists(addr)) begin
            ref_mem[addr]   = '0;
            ref_known[addr] = '0;
        end
        if (wen) begin
            ref_mem[addr]   = (ref_mem[addr] & ~m) | (d & m);
            ref_known[addr] = ref_known[addr] | m;
        end else begin
            e.data  = ref_mem[addr];
            e.known = ref_known[addr];
            e.acc   = cyc;
            sbq.push_back(e);
        end
    endtask

    task automatic issue(input logic wen, input int addr, input logic [DW-1:0] d,
                         input logic [DW-1:0] m);
        @(negedge clk);
        req_valid = 1'b1;
        req_wen   = wen;
        req_addr  = AW'(addr);
        wdata     = d;
        bmask     = m;
        chk("ready_awake", {63'd0, req_ready}, 64'd1);
        model_accept(wen, addr, d, m);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            req_valid = 1'b0;
        end
    endtask

    // Returns at the negedge of the first post-reset cycle.
    task automatic do_reset();
        @(negedge clk);
        rst       = 1'b1;
        req_valid = 1'b0;
        sbq.delete();
        @(negedge clk);
        rst = 1'b0;
        chk("rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
        chk("rst_rdata", rdata, 64'd0);
        chk("rst_ready", {63'd0, req_ready}, 64'd1);
        chk("rst_sleep", {63'd0, sleep_o}, 64'd0);
    endtask

    always @(negedge clk) begin
        if (rsp_valid) begin
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_rsp @cyc %0d: got valid=1 expected valid=0", cyc);
            end else begin
                mon_e = sbq.pop_front();
                chk("rsp_latency", 64'(cyc - mon_e.acc), 64'd2);
                if (mon_e.known != '0) begin
                    chk("rsp_data", rdata & mon_e.known, mon_e.data & mon_e.known);
                end
            end
        end else if (sbq.size() > 0 && (cyc - sbq[0].acc) >= 2) begin
            mon_e = sbq.pop_front();
            checks++;
            errors++;
            $display("FAIL missing_rsp @cyc %0d: got no valid expected valid for read at cyc %0d",
                     cyc, mon_e.acc);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int a;
        int w;
        logic [DW-1:0] d;
        logic [DW-1:0] m;

        rst       = 1'b1;
        req_valid = 1'b0;
        req_wen   = 1'b0;
        req_addr  = '0;
        wdata     = '0;
        bmask     = '0;
        sleep_en  = 1'b0;
        do_reset();

        // Full-mask write then read
        issue(1'b1, 'h005, 64'hDEADBEEF_01234567, '1);
        issue(1'b0, 'h005, '0, '0);
        idle(4);

        // Partial-mask overwrite
        issue(1'b1, 'h400, '1, '1);
        issue(1'b1, 'h400, '0, 64'h0000_0000_FFFF_0000);
        issue(1'b0, 'h400, '0, '0);
        idle(4);

        // Back-to-back reads across three banks
        issue(1'b1, 'h3FF, {$urandom, $urandom}, '1);
        issue(1'b1, 'hC00, {$urandom, $urandom}, '1);
        issue(1'b0, 'h3FF, '0, '0);
        issue(1'b0, 'h400, '0, '0);
        issue(1'b0, 'hC00, '0, '0);
        idle(5);

        // Read immediately after write to the same word
        issue(1'b1, 'h123, 64'h1111_2222_3333_4444, '1);
        idle(2);
        issue(1'b1, 'h123, 64'hA5A5_5A5A_C3C3_3C3C, '1);
        issue(1'b0, 'h123, '0, '0);
        idle(4);

        // Randomised mixed traffic, sleep disabled
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 1) == 0) begin
                a = int'(($urandom_range(0, 3) << 10) | $urandom_range(0, 7));
            end else begin
                a = int'($urandom_range(0, 4095));
            end
            d = {$urandom, $urandom};
            m = ($urandom_range(0, 2) == 0) ? {$urandom, $urandom} : '1;
            issue(1'($urandom_range(0, 1)), a, d, m);
            if ($urandom_range(0, 3) == 0) begin
                idle(int'($urandom_range(1, 3)));
            end
        end
        idle(4);

        // Reset with a read in flight
        issue(1'b0, 'h005, '0, '0);
        do_reset();
        @(negedge clk);
        chk("flush_rsp_valid", {63'd0, rsp_valid}, 64'd0);
        chk("flush_rdata", rdata, 64'd0);
        idle(2);
        issue(1'b0, 'h005, '0, '0);
        idle(4);

        // Light-sleep entry, hold, wake and retention
        sleep_en = 1'b1;
        do_reset();
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            chk("pre_sleep_o_sleep", {63'd0, sleep_o}, 64'd0);
            chk("pre_sleep_ready", {63'd0, req_ready}, 64'd1);
        end
        for (int k = 17; k <= 19; k++) begin
            @(negedge clk);
            chk("sleep_o_sleep", {63'd0, sleep_o}, 64'd1);
            chk("sleep_ready", {63'd0, req_ready}, 64'd0);
            sleep_en = 1'b0;
            if (k == 19) begin
                req_valid = 1'b1;
                req_wen   = 1'b0;
                req_addr  = AW'('h400);
            end
        end
        for (int k = 20; k <= 21; k++) begin
            @(negedge clk);
            chk("wake_o_sleep", {63'd0, sleep_o}, 64'd0);
            chk("wake_ready", {63'd0, req_ready}, 64'd0);
        end
        @(negedge clk);
        chk("awake_ready", {63'd0, req_ready}, 64'd1);
        chk("awake_o_sleep", {63'd0, sleep_o}, 64'd0);
        model_accept(1'b0, 'h400, '0, '0);
        issue(1'b0, 'h005, '0, '0);
        idle(6);

        w = 0;
        while (sbq.size() > 0 && w < 20) begin
            @(negedge clk);
            w++;
        end
        if (sbq.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain: got %0d pending reads expected 0", sbq.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
